timer_counter: RTL

Memory-mapped 32-bit down-counting timer with interrupt, instantiated twice (TC0 at 0x7F00–0x7F0B, TC1 at 0x7F10–0x7F1B) behind the CPU's peripheral bridge. The bridge supplies a word address, a full-word write strobe and write data, reads back `dout` combinationally, and routes `irq` into HWInt[0]/HWInt[1]. The block has three registers (CTRL, PRESET, COUNT) and a four-state FSM that supports one-shot and auto-reload modes.

---
 rtl/tc_pkg.sv | 31 +++
 rtl/timer_counter.sv | 113 +++++++++++
 2 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the timer_counter peripheral and the bridge that
// decodes it.
//   - FSM state encoding
//   - register word offsets (addr[3:2])
//   - CTRL bit positions and mode codes
//   - TC0/TC1 base byte addresses on the peripheral bridge
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with interrupt.
// Registers (addr[3:2]): 0 CTRL[3:0] R/W, 1 PRESET R/W, 2 COUNT RO, 3 reads 0.
// CTRL: [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot), [3] IM.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   addr  - word address from the bridge; only addr[3:2] is decoded
//   we    - full-word write strobe
//   din   - write data
//   dout  - combinational read data for addr[3:2]
//   irq   - interrupt request, irq_flag gated by CTRL.IM
module timer_counter
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  tc_state_e   state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  reg_sel;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload_mode;
  logic        unused_addr;

  assign reg_sel     = addr[3:2];
  assign ctrl_wr     = we && (reg_sel == ADDR_CTRL);
  assign preset_wr   = we && (reg_sel == ADDR_PRESET);
  assign reload_mode = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign unused_addr = ^addr[31:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      // Assignment order sets the collision priorities: the CTRL-write clear
      // of irq_flag precedes the FSM so INT can re-set it, while the CTRL
      // register write follows the FSM so it overrides INT clearing EN.
      if (ctrl_wr) begin
        irq_flag <= 1'b0;
      end

      if (preset_wr) begin
        preset <= din;
      end

      unique case (state)
        IDLE: begin
          if (reload_mode) begin
            irq_flag <= 1'b0;
          end
          if (ctrl[CTRL_EN]) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // Covers both 1 and 0, so PRESET=0 gets a single CNT cycle too.
            count <= '0;
            state <= INT;
          end
        end
        INT: begin
          irq_flag <= 1'b1;
          if (!reload_mode) begin
            ctrl[CTRL_EN] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (ctrl_wr) begin
        ctrl <= din[3:0];
      end
    end
  end

  always_comb begin
    dout = '0;
    unique case (reg_sel)
      ADDR_CTRL:   dout = {28'd0, ctrl};
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = '0;
    endcase
  end

  assign irq = irq_flag & ctrl[CTRL_IM];

endmodule
